// File: rtl/microsequencer_if.sv
// microsequencer_if: bundles the sequencer's control inputs and status outputs.
//   stall   : 1 = hold state and retired counter this cycle
//   Op      : instruction opcode, only looked at on dispatch edges
//   NS      : current control state (registered)
//   addrctl : AddrCtl code of the current state
//   illegal : high while the sequencer sits in the trap state
//   retired : retired-instruction count
// master = the side driving stall/Op (CPU datapath / testbench)
// slave  = the sequencer itself
interface microsequencer_if #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6,
  parameter int CNT_W   = 16
);
  logic               stall;
  logic [OP_W-1:0]    Op;
  logic [STATE_W-1:0] NS;
  logic [1:0]         addrctl;
  logic               illegal;
  logic [CNT_W-1:0]   retired;

  modport master (output stall, Op, input NS, addrctl, illegal, retired);
  modport slave  (input stall, Op, output NS, addrctl, illegal, retired);
endinterface

// File: rtl/microsequencer.sv
// microsequencer: microprogrammed control sequencer for the multicycle CPU.
// Each state carries a 2-bit AddrCtl code from an internal ROM (ADDRCTL_TAB)
// that selects where the next state comes from: back to fetch, one of two
// opcode dispatch tables, or the next sequential state. Illegal opcodes at
// the first dispatch go to TRAP_STATE. A counter tracks retired instructions.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : microsequencer_if.slave (stall, Op in; NS, addrctl, illegal, retired out)
module microsequencer #(
  parameter int STATE_W    = 4,
  parameter int OP_W       = 6,
  parameter int CNT_W      = 16,
  parameter int TRAP_STATE = 13,
  parameter logic [2*(2**STATE_W)-1:0] ADDRCTL_TAB = 32'h0030_30E7
) (
  input logic              clk,
  input logic              rst,
  microsequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    AC_FETCH = 2'd0,
    AC_DISP1 = 2'd1,
    AC_DISP2 = 2'd2,
    AC_SEQ   = 2'd3
  } addrctl_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  localparam logic [STATE_W-1:0] S_TRAP = STATE_W'(TRAP_STATE);
  localparam logic [STATE_W-1:0] S_MAX  = '1;

  logic [STATE_W-1:0] ns_q, ns_d, next_state;
  logic [CNT_W-1:0]   retired_q, retired_d;
  addrctl_e           code;
  logic               completes;

  function automatic logic [STATE_W-1:0] disp1(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_SW: disp1 = STATE_W'(2);
      OP_RTYPE:     disp1 = STATE_W'(6);
      OP_BEQ:       disp1 = STATE_W'(8);
      OP_J:         disp1 = STATE_W'(9);
      OP_ADDI:      disp1 = STATE_W'(10);
      OP_BNE:       disp1 = STATE_W'(12);
      default:      disp1 = S_TRAP;
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] disp2(input logic [OP_W-1:0] op);
    case (op)
      OP_LW:   disp2 = STATE_W'(3);
      OP_SW:   disp2 = STATE_W'(5);
      default: disp2 = S_TRAP;
    endcase
  endfunction

  // ROM lookup: state s owns bits [2s+1:2s] of the table.
  assign code = addrctl_e'(ADDRCTL_TAB[{ns_q, 1'b0} +: 2]);

  always_comb begin
    next_state = '0;
    ns_d       = ns_q;
    retired_d  = retired_q;
    case (code)
      AC_FETCH: next_state = '0;
      AC_DISP1: next_state = disp1(bus.Op);
      AC_DISP2: next_state = disp2(bus.Op);
      AC_SEQ:   next_state = ns_q + STATE_W'(1);
      default:  next_state = '0;
    endcase
    // An instruction retires when control returns to 0 from a real
    // instruction state; a SEQ wrap off the top state also lands on 0.
    // Leaving the trap state and idling in state 0 are not retirements.
    completes = ((code == AC_FETCH) || (code == AC_SEQ && ns_q == S_MAX)) &&
                (ns_q != '0) && (ns_q != S_TRAP);
    if (!bus.stall) begin
      ns_d = next_state;
      if (completes) retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_q      <= '0;
      retired_q <= '0;
    end else begin
      ns_q      <= ns_d;
      retired_q <= retired_d;
    end
  end

  assign bus.NS      = ns_q;
  assign bus.addrctl = code;
  assign bus.illegal = (ns_q == S_TRAP);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_microsequencer.sv
// Randomized scoreboard bench for microsequencer. The reference model walks
// each instruction's documented state path; a negedge monitor compares every
// cycle. A second instance with CNT_W=2 shares the stimulus to exercise the
// counter wrap.
module tb_microsequencer;
  localparam logic [31:0] TAB = 32'h0030_30E7;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RTYPE = 6'b000000,
                         BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000,
                         BNE = 6'b000101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  microsequencer_if #(.STATE_W(4), .OP_W(6), .CNT_W(16)) bus ();
  microsequencer_if #(.STATE_W(4), .OP_W(6), .CNT_W(2))  bus2 ();
  assign bus2.stall = bus.stall;
  assign bus2.Op    = bus.Op;

  microsequencer #(.CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  microsequencer #(.CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct { int ns; int ret; } exp_t;
  exp_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  m_ns = 0;
  int  m_ret = 0;
  bit  chk_en = 1'b0;

  function automatic logic [1:0] ac_of(input int s);
    logic [31:0] t;
    t = TAB >> (2 * s);
    return t[1:0];
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RTYPE, BEQ, J, ADDI, BNE};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("NS",         32'(bus.NS),      32'(e.ns));
    cmp("addrctl",    32'(bus.addrctl), 32'(ac_of(e.ns)));
    cmp("illegal",    32'(bus.illegal), 32'(e.ns == 13));
    cmp("retired",    32'(bus.retired), 32'(e.ret & 32'hFFFF));
    cmp("NS_w2",      32'(bus2.NS),     32'(e.ns));
    cmp("retired_w2", 32'(bus2.retired), 32'(e.ret & 3));
  endtask

  // Monitor: every negedge, the DUT's registered outputs must match the
  // oldest pending expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard: got empty queue expected an entry (t=%0t)", $time);
      end else begin
        check_all(q.pop_front());
      end
    end
  end

  // Walk one instruction along its documented state path. Op carries the
  // real opcode only on non-stalled dispatch cycles; otherwise it is noise
  // that must be ignored.
  task automatic run_instr(input logic [5:0] op);
    int p[$];
    int i;
    bit st;
    case (op)
      LW:      p = '{0, 1, 2, 3, 4};
      SW:      p = '{0, 1, 2, 5};
      RTYPE:   p = '{0, 1, 6, 7};
      BEQ:     p = '{0, 1, 8};
      J:       p = '{0, 1, 9};
      ADDI:    p = '{0, 1, 10, 11};
      BNE:     p = '{0, 1, 12};
      default: p = '{0, 1, 13};
    endcase
    i = 0;
    while (i < p.size()) begin
      st = ($urandom_range(0, 3) == 0);
      bus.stall = st;
      if ((p[i] == 1 || p[i] == 2) && !st) bus.Op = op;
      else                                 bus.Op = 6'($urandom);
      @(posedge clk);
      #1;
      if (!st) begin
        i++;
        if (i == p.size() && p[p.size()-1] != 13) m_ret++;
      end
      m_ns = (i < p.size()) ? p[i] : 0;
      q.push_back('{m_ns, m_ret});
      chk_en = 1'b1;
    end
  endtask

  task automatic run_random(input int n);
    logic [5:0] ops [7];
    logic [5:0] op;
    int k;
    ops = '{LW, SW, RTYPE, BEQ, J, ADDI, BNE};
    for (int j = 0; j < n; j++) begin
      k = $urandom_range(0, 7);
      if (k == 7) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[k];
      end
      run_instr(op);
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.Op    = 6'd0;
    rst       = 1'b1;
    #12;
    cmp("rst_NS",      32'(bus.NS), 0);
    cmp("rst_addrctl", 32'(bus.addrctl), 3);
    cmp("rst_illegal", 32'(bus.illegal), 0);
    cmp("rst_retired", 32'(bus.retired), 0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(LW);
    run_instr(SW);
    run_instr(BNE);
    run_instr(6'b111111);
    run_instr(BEQ);
    for (int j = 0; j < 5; j++) run_instr(J);
    run_random(250);

    // Asynchronous reset in the middle of an LW (NS=3), no clock edge.
    bus.stall = 1'b0;
    bus.Op    = LW;
    for (int s = 1; s <= 3; s++) begin
      @(posedge clk);
      #1;
      m_ns = s;
      if (s < 3) q.push_back('{m_ns, m_ret});
    end
    chk_en = 1'b0;
    #1;
    cmp("pre_rst_NS", 32'(bus.NS), 3);
    q.delete();
    rst = 1'b1;
    #1;
    cmp("mid_rst_NS",      32'(bus.NS), 0);
    cmp("mid_rst_retired", 32'(bus.retired), 0);
    cmp("mid_rst_ret_w2",  32'(bus2.retired), 0);
    cmp("mid_rst_addrctl", 32'(bus.addrctl), 3);
    cmp("mid_rst_illegal", 32'(bus.illegal), 0);
    m_ns  = 0;
    m_ret = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int j = 0; j < 5; j++) run_instr(J);
    run_random(60);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
